// File: rtl/sbox_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : sbox_share_sched
// Brief    : NUM_SBOX shared AES forward S-boxes time-multiplexed between a
//            128-bit SubBytes requester and a 32-bit SubWord requester.
//            Optional macro SBOX_SCHED_PERF_EN adds stall/job counters.
// Revision : 1.0 - initial release
// ============================================================================
module sbox_share_sched #(
    parameter int NUM_SBOX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_in_valid,
    output logic         st_in_ready,
    input  logic [127:0] st_in_data,
    output logic         st_out_valid,
    input  logic         st_out_ready,
    output logic [127:0] st_out_data,
    input  logic         wd_in_valid,
    output logic         wd_in_ready,
    input  logic [31:0]  wd_in_data,
    output logic         wd_out_valid,
    input  logic         wd_out_ready,
    output logic [31:0]  wd_out_data,
    output logic         busy
`ifdef SBOX_SCHED_PERF_EN
    ,
    output logic [15:0]  perf_st_stall,
    output logic [15:0]  perf_wd_stall,
    output logic [15:0]  perf_jobs
`endif
);

    localparam int c_chunks = 16 / NUM_SBOX;
    localparam int c_cw     = (c_chunks > 1) ? $clog2(c_chunks) : 1;
    localparam int c_lw     = 8 * NUM_SBOX;
    localparam logic [c_cw-1:0] c_last    = c_cw'(c_chunks - 1);
    localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
    localparam logic c_src_st = 1'b0;
    localparam logic c_src_wd = 1'b1;

    localparam logic [0:255][7:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    generate
        if (NUM_SBOX != 4 && NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
            $error("sbox_share_sched: NUM_SBOX must be 4, 8 or 16");
        end
    endgenerate

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return c_sbox[x];
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [c_cw-1:0]   r_cnt;
    logic              r_last_grant;
    logic              r_src;
    logic [127:0]      r_work;
    logic [127:0]      w_work_next;
    logic [c_lw-1:0]   w_lk_in;
    logic [c_lw-1:0]   w_lk_out;
    logic [6:0]        w_base;
    logic              w_grant_wd;
    logic              w_grant_st;
    logic              w_accept;
    logic              w_final;
    logic              w_out_ready;

    // Round-robin on a tie: the requester not served last wins.
    assign w_grant_wd  = wd_in_valid && (!st_in_valid || (r_last_grant == c_src_st));
    assign w_grant_st  = st_in_valid && !w_grant_wd;
    assign st_in_ready = rst_n && (r_state == IDLE) && w_grant_st;
    assign wd_in_ready = rst_n && (r_state == IDLE) && w_grant_wd;
    assign w_accept    = st_in_ready || wd_in_ready;
    assign busy        = (r_state != IDLE);
    assign w_final     = (r_src == c_src_wd) || (r_cnt == c_last);
    assign w_out_ready = (r_src == c_src_wd) ? wd_out_ready : st_out_ready;
    assign w_base      = 7'(127 - c_lw * int'(r_cnt));

    always_comb begin
        w_lk_in = r_work[w_base -: c_lw];
        if (r_src == c_src_wd) begin
            w_lk_in[31:0] = r_work[31:0];
        end
    end

    for (genvar i = 0; i < NUM_SBOX; i++) begin : g_lookup
        assign w_lk_out[8*i +: 8] = sbox(w_lk_in[8*i +: 8]);
    end

    // A word job only writes back lookups 0..3; the rest are ignored.
    always_comb begin
        w_work_next = r_work;
        if (r_src == c_src_wd) begin
            w_work_next[31:0] = w_lk_out[31:0];
        end else begin
            w_work_next[w_base -: c_lw] = w_lk_out;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_state_next = LOOKUP;
            LOOKUP:  if (w_final)     w_state_next = DONE;
            DONE:    if (w_out_ready) w_state_next = IDLE;
            default:                  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_last_grant <= c_src_st;
            r_src        <= c_src_st;
            r_work       <= '0;
            st_out_valid <= 1'b0;
            wd_out_valid <= 1'b0;
            st_out_data  <= '0;
            wd_out_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_src        <= wd_in_ready;
                        r_last_grant <= wd_in_ready;
                        r_cnt        <= '0;
                        r_work       <= wd_in_ready ? {96'd0, wd_in_data} : st_in_data;
                    end
                end
                LOOKUP: begin
                    r_work <= w_work_next;
                    r_cnt  <= r_cnt + c_cnt_one;
                    if (w_final) begin
                        if (r_src == c_src_wd) begin
                            wd_out_data  <= w_work_next[31:0];
                            wd_out_valid <= 1'b1;
                        end else begin
                            st_out_data  <= w_work_next;
                            st_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (w_out_ready) begin
                        st_out_valid <= 1'b0;
                        wd_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SBOX_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_st_stall <= '0;
            perf_wd_stall <= '0;
            perf_jobs     <= '0;
        end else begin
            if (st_in_valid && !st_in_ready && perf_st_stall != 16'hFFFF) begin
                perf_st_stall <= perf_st_stall + 16'd1;
            end
            if (wd_in_valid && !wd_in_ready && perf_wd_stall != 16'hFFFF) begin
                perf_wd_stall <= perf_wd_stall + 16'd1;
            end
            if (w_accept && perf_jobs != 16'hFFFF) begin
                perf_jobs <= perf_jobs + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sbox_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbox_share_sched
// Brief    : Directed vector bench for sbox_share_sched (NUM_SBOX = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sbox_share_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         st_in_valid, st_in_ready, st_out_valid, st_out_ready;
    logic [127:0] st_in_data, st_out_data;
    logic         wd_in_valid, wd_in_ready, wd_out_valid, wd_out_ready;
    logic [31:0]  wd_in_data, wd_out_data;
    logic         busy;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] c_st_a   = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] c_st_a_s = 128'h63cab7040953d051cd60e0e7ba70e18c;
    localparam logic [31:0]  c_wd_b   = 32'hcf4f3c09;
    localparam logic [31:0]  c_wd_b_s = 32'h8a84eb01;

    sbox_share_sched #(.NUM_SBOX(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_in_valid  (st_in_valid),
        .st_in_ready  (st_in_ready),
        .st_in_data   (st_in_data),
        .st_out_valid (st_out_valid),
        .st_out_ready (st_out_ready),
        .st_out_data  (st_out_data),
        .wd_in_valid  (wd_in_valid),
        .wd_in_ready  (wd_in_ready),
        .wd_in_data   (wd_in_data),
        .wd_out_valid (wd_out_valid),
        .wd_out_ready (wd_out_ready),
        .wd_out_data  (wd_out_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_wd;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic is_wd, input logic [127:0] din,
                           input logic [127:0] exp, input int exp_lat, input string tag);
        int n;
        int lat;
        int busy_n;
        if (is_wd) begin
            wd_in_data  = din[31:0];
            wd_in_valid = 1'b1;
        end else begin
            st_in_data  = din;
            st_in_valid = 1'b1;
        end
        #1;
        n = 0;
        while (!(is_wd ? wd_in_ready : st_in_ready) && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_ready"}, 128'(is_wd ? wd_in_ready : st_in_ready), 128'(1));
        step();
        st_in_valid = 1'b0;
        wd_in_valid = 1'b0;
        busy_n = int'(busy);
        lat = 0;
        while (!(is_wd ? wd_out_valid : st_out_valid) && lat < 50) begin
            step();
            lat++;
            busy_n += int'(busy);
        end
        chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        chk({tag, "_data"}, is_wd ? 128'(wd_out_data) : st_out_data, exp);
        chk({tag, "_other_valid"}, 128'(is_wd ? st_out_valid : wd_out_valid), 128'(0));
        step();
        chk({tag, "_busy_cycles"}, 128'(busy_n), 128'(exp_lat + 1));
        chk({tag, "_after_hs"}, {126'd0, st_out_valid | wd_out_valid, busy}, 128'(0));
        chk({tag, "_data_held"}, is_wd ? 128'(wd_out_data) : st_out_data, exp);
    endtask

    initial begin
        int n;
        logic flag;
        logic exp_wd;

        vecs[0] = '{1'b0, c_st_a, c_st_a_s};
        vecs[1] = '{1'b1, 128'(c_wd_b), 128'(c_wd_b_s)};
        vecs[2] = '{1'b0, 128'h0, {16{8'h63}}};
        vecs[3] = '{1'b0, {16{8'hff}}, {16{8'h16}}};
        vecs[4] = '{1'b1, 128'h01234567, 128'h7c266e85};
        vecs[5] = '{1'b0, 128'h0123456789abcdeffedcba9876543210,
                          128'h7c266e85a762bddfbb86f4463820_23ca};

        rst_n        = 1'b0;
        st_in_valid  = 1'b1;
        wd_in_valid  = 1'b1;
        st_in_data   = c_st_a;
        wd_in_data   = c_wd_b;
        st_out_ready = 1'b1;
        wd_out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready", {126'd0, st_in_ready, wd_in_ready}, 128'(0));
        chk("rst_out_valid", {126'd0, st_out_valid, wd_out_valid}, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_st_data", st_out_data, 128'(0));
        chk("rst_wd_data", 128'(wd_out_data), 128'(0));
        st_in_valid = 1'b0;
        wd_in_valid = 1'b0;
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].is_wd, vecs[i].din, vecs[i].exp, vecs[i].is_wd ? 1 : 4,
                    $sformatf("vec%0d", i));
        end

        // Contention straight after reset: WD, ST, WD, ST.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        st_in_data  = c_st_a;
        wd_in_data  = c_wd_b;
        st_in_valid = 1'b1;
        wd_in_valid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_wd = (g % 2 == 0);
            #1;
            n = 0;
            while (!(st_in_ready || wd_in_ready) && n < 50) begin
                step();
                n++;
            end
            chk($sformatf("rr_grant%0d", g), {126'd0, wd_in_ready, st_in_ready},
                exp_wd ? 128'(2) : 128'(1));
            step();
            n = 0;
            while (!(st_out_valid || wd_out_valid) && n < 50) begin
                step();
                n++;
            end
            chk($sformatf("rr_data%0d", g), exp_wd ? 128'(wd_out_data) : st_out_data,
                exp_wd ? 128'(c_wd_b_s) : c_st_a_s);
            step();
        end
        st_in_valid = 1'b0;
        wd_in_valid = 1'b0;
        step();

        // Backpressure on the state result with a word request pending.
        st_out_ready = 1'b0;
        st_in_data   = c_st_a;
        st_in_valid  = 1'b1;
        #1;
        n = 0;
        while (!st_in_ready && n < 50) begin
            step();
            n++;
        end
        step();
        st_in_valid = 1'b0;
        wd_in_data  = c_wd_b;
        wd_in_valid = 1'b1;
        n = 0;
        while (!st_out_valid && n < 50) begin
            step();
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp_hold%0d", c), {st_out_valid, wd_in_ready, st_out_data[125:0]},
                {1'b1, 1'b0, c_st_a_s[125:0]});
            if (c < 9) step();
        end
        st_out_ready = 1'b1;
        step();
        chk("bp_handshake", {126'd0, st_out_valid, wd_in_ready}, 128'(1));
        step();
        wd_in_valid = 1'b0;
        step();
        chk("bp_wd_result", {95'd0, wd_out_valid, wd_out_data}, {95'd0, 1'b1, c_wd_b_s});
        step();

        // Reset while the third chunk is pending.
        st_in_data  = 128'h0123456789abcdeffedcba9876543210;
        st_in_valid = 1'b1;
        #1;
        n = 0;
        while (!st_in_ready && n < 50) begin
            step();
            n++;
        end
        step();
        st_in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_ctrl", {125'd0, busy, st_out_valid, wd_out_valid}, 128'(0));
        chk("mid_rst_st_data", st_out_data, 128'(0));
        chk("mid_rst_wd_data", 128'(wd_out_data), 128'(0));
        flag = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            flag = flag | st_out_valid | wd_out_valid | busy;
        end
        chk("mid_rst_no_stale", 128'(flag), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
